// File: rtl/fp_dispatch_pkg.sv
// rtl/fp_dispatch_pkg.sv - shared types for the FP dispatch block
// Purpose: command encoding, FSM states, tag width and FIFO entry layout.
// Ports: none (package).
package fp_dispatch_pkg;

   typedef enum logic [2:0] {
      COMMAND_NOP          = 3'd0,
      COMMAND_OP_FLOAT_INT = 3'd1,
      COMMAND_OP_INT_FLOAT = 3'd2,
      COMMAND_OP_ADD       = 3'd3,
      COMMAND_OP_MUL       = 3'd4
   } Commands;

   localparam int TAG_WIDTH = 4;

   typedef enum logic [1:0] {
      STATE_IDLE  = 2'd0,
      STATE_ISSUE = 2'd1,
      STATE_RESP  = 2'd2
   } States;

   typedef struct packed {
      Commands                command;
      logic [31:0]            operand1;
      logic [31:0]            operand2;
      logic [TAG_WIDTH-1:0]   tag;
   } Request;

   localparam int REQUEST_WIDTH = $bits(Request);

   // Only the two conversion operations are wired to the core.
   function automatic logic isSupported(input Commands command);
      return (command == COMMAND_OP_FLOAT_INT) || (command == COMMAND_OP_INT_FLOAT);
   endfunction

endpackage

// File: rtl/fp_dispatch_fifo.sv
// rtl/fp_dispatch_fifo.sv - request FIFO for the FP dispatch block
// Purpose: DEPTH-entry (power of two) in-order FIFO with first-word head view.
// Ports: aClock, aReset_n (async low), aPush/aPushData, aPop, aHeadData,
//        aFull, anEmpty. Push while full and pop while empty are ignored.
module fp_dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             aClock,
   input  logic             aReset_n,
   input  logic             aPush,
   input  logic [WIDTH-1:0] aPushData,
   input  logic             aPop,
   output logic [WIDTH-1:0] aHeadData,
   output logic             aFull,
   output logic             anEmpty
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   logic [WIDTH-1:0]     entries [DEPTH];
   logic [PTR_WIDTH-1:0] writePtr;
   logic [PTR_WIDTH-1:0] readPtr;
   logic [PTR_WIDTH:0]   count;
   logic                 doPush;
   logic                 doPop;

   assign aFull     = (count == (PTR_WIDTH+1)'(DEPTH));
   assign anEmpty   = (count == '0);
   assign doPush    = aPush && !aFull;
   assign doPop     = aPop && !anEmpty;
   assign aHeadData = entries[readPtr];

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
   always_ff @(posedge aClock or negedge aReset_n) begin
      if (!aReset_n) begin
         writePtr <= '0;
         readPtr  <= '0;
         count    <= '0;
      end else begin
         if (doPush) writePtr <= writePtr + PTR_WIDTH'(1);
         if (doPop)  readPtr  <= readPtr + PTR_WIDTH'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + (PTR_WIDTH+1)'(1);
            2'b01:   count <= count - (PTR_WIDTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge aClock) begin
      if (doPush) entries[writePtr] <= aPushData;
   end

endmodule

// File: rtl/fp_dispatch.sv
// rtl/fp_dispatch.sv - request FIFO plus IDLE/ISSUE/RESP dispatcher to an FP core
// Purpose: queue requests, issue supported conversions to the core for LATENCY
//          cycles, hold one response until accepted.
// Ports: aClock, aReset_n (async low); request aReqValid/aReqReady/aReqCommand/
//        aReqOperand1/aReqOperand2/aReqTag; core aCoreCommand/aCoreInput1/
//        aCoreInput2/aCoreOutput; response aRespValid/aRespReady/aRespData/
//        aRespTag/aRespError; anIdle.
// Option: FP_DISPATCH_PERF_EN adds anOpCount (16-bit response handshake count).
module fp_dispatch
   import fp_dispatch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 1
) (
   input  logic                 aClock,
   input  logic                 aReset_n,
   input  logic                 aReqValid,
   output logic                 aReqReady,
   input  Commands              aReqCommand,
   input  logic [31:0]          aReqOperand1,
   input  logic [31:0]          aReqOperand2,
   input  logic [TAG_WIDTH-1:0] aReqTag,
   output Commands              aCoreCommand,
   output logic [31:0]          aCoreInput1,
   output logic [31:0]          aCoreInput2,
   input  logic [31:0]          aCoreOutput,
   output logic                 aRespValid,
   input  logic                 aRespReady,
   output logic [31:0]          aRespData,
   output logic [TAG_WIDTH-1:0] aRespTag,
   output logic                 aRespError,
   output logic                 anIdle
`ifdef FP_DISPATCH_PERF_EN
   ,
   output logic [15:0]          anOpCount
`endif
);

   States      state, stateNext;
   logic [2:0] issueCount, issueCountNext;
   Request     pushEntry;
   Request     head;
   logic       fifoFull;
   logic       fifoEmpty;
   logic       fifoPop;
   logic       loadCore;
   logic       captureResult;
   logic       captureError;

   assign pushEntry = '{command: aReqCommand, operand1: aReqOperand1,
                        operand2: aReqOperand2, tag: aReqTag};

   fp_dispatch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQUEST_WIDTH)
   ) requestFifo (
      .aClock    (aClock),
      .aReset_n  (aReset_n),
      .aPush     (aReqValid),
      .aPushData (pushEntry),
      .aPop      (fifoPop),
      .aHeadData (head),
      .aFull     (fifoFull),
      .anEmpty   (fifoEmpty)
   );

   assign aReqReady = !fifoFull;
   assign anIdle    = fifoEmpty && (state == STATE_IDLE);

   always_ff @(posedge aClock or negedge aReset_n) begin
      if (!aReset_n) begin
         state      <= STATE_IDLE;
         issueCount <= '0;
      end else begin
         state      <= stateNext;
         issueCount <= issueCountNext;
      end
   end

   // The head entry stays in the FIFO through ISSUE so its tag is still
   // available at capture time; it is popped on the edge that enters RESP.
   always_comb begin
      stateNext      = state;
      issueCountNext = issueCount;
      fifoPop        = 1'b0;
      loadCore       = 1'b0;
      captureResult  = 1'b0;
      captureError   = 1'b0;
      aRespValid     = 1'b0;
      case (state)
         STATE_IDLE: begin
            if (!fifoEmpty) begin
               if (isSupported(head.command)) begin
                  loadCore       = 1'b1;
                  issueCountNext = '0;
                  stateNext      = STATE_ISSUE;
               end else begin
                  captureError = 1'b1;
                  fifoPop      = 1'b1;
                  stateNext    = STATE_RESP;
               end
            end
         end
         STATE_ISSUE: begin
            if (issueCount == 3'(LATENCY - 1)) begin
               captureResult = 1'b1;
               fifoPop       = 1'b1;
               stateNext     = STATE_RESP;
            end else begin
               issueCountNext = issueCount + 3'd1;
            end
         end
         STATE_RESP: begin
            aRespValid = 1'b1;
            if (aRespReady) stateNext = STATE_IDLE;
         end
         default: stateNext = STATE_IDLE;
      endcase
   end

   always_ff @(posedge aClock or negedge aReset_n) begin
      if (!aReset_n) begin
         aCoreCommand <= COMMAND_NOP;
         aCoreInput1  <= '0;
         aCoreInput2  <= '0;
         aRespData    <= '0;
         aRespTag     <= '0;
         aRespError   <= 1'b0;
      end else begin
         if (loadCore) begin
            aCoreCommand <= head.command;
            aCoreInput1  <= head.operand1;
            aCoreInput2  <= head.operand2;
         end
         if (captureResult) begin
            aRespData  <= aCoreOutput;
            aRespTag   <= head.tag;
            aRespError <= 1'b0;
         end
         if (captureError) begin
            aRespData  <= '0;
            aRespTag   <= head.tag;
            aRespError <= 1'b1;
         end
      end
   end

`ifdef FP_DISPATCH_PERF_EN
   always_ff @(posedge aClock or negedge aReset_n) begin
      if (!aReset_n) anOpCount <= '0;
      else if (aRespValid && aRespReady) anOpCount <= anOpCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fp_dispatch.sv
// tb/tb_fp_dispatch.sv - self-checking bench for fp_dispatch
// Purpose: directed latency/ordering/error/reset scenarios plus randomized
//          traffic against a queue-based reference model and a behavioural core.
// Ports: none (top-level bench).
module tb_fp_dispatch;
   import fp_dispatch_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   Commands     reqCommand = COMMAND_NOP;
   logic [31:0] reqOperand1 = '0;
   logic [31:0] reqOperand2 = '0;
   logic [3:0]  reqTag = '0;
   Commands     coreCommand;
   logic [31:0] coreInput1;
   logic [31:0] coreInput2;
   logic [31:0] coreOutput;
   logic        respValid;
   logic        respReady = 1'b0;
   logic [31:0] respData;
   logic [3:0]  respTag;
   logic        respError;
   logic        idle;
`ifdef FP_DISPATCH_PERF_EN
   logic [15:0] opCount;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        error;
   } Expected;
   Expected expectQ[$];

   always #5 clock = ~clock;

   fp_dispatch dut (
      .aClock       (clock),
      .aReset_n     (reset_n),
      .aReqValid    (reqValid),
      .aReqReady    (reqReady),
      .aReqCommand  (reqCommand),
      .aReqOperand1 (reqOperand1),
      .aReqOperand2 (reqOperand2),
      .aReqTag      (reqTag),
      .aCoreCommand (coreCommand),
      .aCoreInput1  (coreInput1),
      .aCoreInput2  (coreInput2),
      .aCoreOutput  (coreOutput),
      .aRespValid   (respValid),
      .aRespReady   (respReady),
      .aRespData    (respData),
      .aRespTag     (respTag),
      .aRespError   (respError),
      .anIdle       (idle)
`ifdef FP_DISPATCH_PERF_EN
      ,
      .anOpCount    (opCount)
`endif
   );

   function automatic logic [31:0] intToFloat(input logic [31:0] v);
      logic        sign;
      logic [31:0] mag;
      logic [31:0] frac;
      int          msb;
      sign = v[31];
      mag  = sign ? -v : v;
      if (mag == 0) return 32'h0;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      if (msb > 23) frac = mag >> (msb - 23);
      else          frac = mag << (23 - msb);
      return {sign, 8'(127 + msb), frac[22:0]};
   endfunction

   function automatic logic [31:0] floatToInt(input logic [31:0] f);
      int          e;
      int          sh;
      logic [31:0] mant;
      logic [31:0] r;
      e = int'(f[30:23]);
      if (e < 127) return 32'h0;
      sh = e - 127;
      if (sh > 30) return f[31] ? 32'h80000000 : 32'h7FFFFFFF;
      mant = {9'b0, 1'b1, f[22:0]};
      if (sh >= 23) r = mant << (sh - 23);
      else          r = mant >> (23 - sh);
      return f[31] ? -r : r;
   endfunction

   function automatic logic [31:0] coreFunc(input Commands c, input logic [31:0] a,
                                             input logic [31:0] b);
      case (c)
         COMMAND_OP_FLOAT_INT: return floatToInt(a);
         COMMAND_OP_INT_FLOAT: return intToFloat(a);
         default:              return a ^ b;
      endcase
   endfunction

   assign coreOutput = coreFunc(coreCommand, coreInput1, coreInput2);

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({reqReady, respValid, respError, idle} !== 4'b1001) begin
         failures++;
         $display("FAIL reset_flags got ready/valid/err/idle=%b%b%b%b want 1001",
                  reqReady, respValid, respError, idle);
      end
      checks++;
      if ({coreCommand, coreInput1, coreInput2, respData, respTag} !== '0) begin
         failures++;
         $display("FAIL reset_regs got cmd=%0d in1=%h in2=%h data=%h tag=%0d want all 0",
                  coreCommand, coreInput1, coreInput2, respData, respTag);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_float_int();
      reqValid = 1'b1; reqCommand = COMMAND_OP_FLOAT_INT;
      reqOperand1 = 32'h3F800000; reqOperand2 = '0; reqTag = 4'd3;
      @(posedge clock);          // E0
      @(negedge clock); reqValid = 1'b0;
      checks++;
      if (respValid !== 1'b0) begin
         failures++; $display("FAIL fi_valid_e0 got %b want 0", respValid);
      end
      @(negedge clock);          // after E1: in ISSUE
      checks++;
      if ({respValid, coreCommand} !== {1'b0, COMMAND_OP_FLOAT_INT}) begin
         failures++;
         $display("FAIL fi_issue got valid=%b cmd=%0d want 0/%0d", respValid, coreCommand,
                  COMMAND_OP_FLOAT_INT);
      end
      @(negedge clock);          // after E2: response held
      checks++;
      if ({respValid, respData, respTag, respError} !== {1'b1, 32'h1, 4'd3, 1'b0}) begin
         failures++;
         $display("FAIL fi_resp got v=%b d=%h t=%0d e=%b want 1/00000001/3/0",
                  respValid, respData, respTag, respError);
      end
      respReady = 1'b1;
      @(negedge clock);
      respReady = 1'b0;
      checks++;
      if ({respValid, idle} !== 2'b01) begin
         failures++; $display("FAIL fi_release got valid=%b idle=%b want 0/1", respValid, idle);
      end
   endtask

   task automatic test_int_float();
      logic [3:0] tag;
      tag = 4'($urandom_range(0, 15));
      reqValid = 1'b1; reqCommand = COMMAND_OP_INT_FLOAT;
      reqOperand1 = 32'h00000005; reqOperand2 = 32'hA5A5A5A5; reqTag = tag;
      @(posedge clock);
      @(negedge clock); reqValid = 1'b0;
      @(negedge clock);
      checks++;
      if (coreCommand !== COMMAND_OP_INT_FLOAT) begin
         failures++; $display("FAIL if_issue_cmd got %0d want %0d", coreCommand,
                              COMMAND_OP_INT_FLOAT);
      end
      @(negedge clock);
      checks++;
      if ({respValid, respData, respTag, respError} !== {1'b1, 32'h40A00000, tag, 1'b0}) begin
         failures++;
         $display("FAIL if_resp got v=%b d=%h t=%0d e=%b want 1/40a00000/%0d/0",
                  respValid, respData, respTag, respError, tag);
      end
      respReady = 1'b1;
      @(negedge clock);
      respReady = 1'b0;
   endtask

   task automatic test_unsupported();
      reqValid = 1'b1; reqCommand = COMMAND_OP_ADD;
      reqOperand1 = 32'h12345678; reqOperand2 = 32'h0F0F0F0F; reqTag = 4'd9;
      @(posedge clock);
      @(negedge clock); reqValid = 1'b0;
      checks++;
      if (respValid !== 1'b0) begin
         failures++; $display("FAIL un_valid_e0 got %b want 0", respValid);
      end
      @(negedge clock);          // one edge later: straight to RESP
      checks++;
      if ({respValid, respData, respTag, respError} !== {1'b1, 32'h0, 4'd9, 1'b1}) begin
         failures++;
         $display("FAIL un_resp got v=%b d=%h t=%0d e=%b want 1/00000000/9/1",
                  respValid, respData, respTag, respError);
      end
      checks++;
      if ({coreCommand, coreInput1} !== {COMMAND_OP_INT_FLOAT, 32'h5}) begin
         failures++;
         $display("FAIL un_core_hold got cmd=%0d in1=%h want %0d/00000005",
                  coreCommand, coreInput1, COMMAND_OP_INT_FLOAT);
      end
      respReady = 1'b1;
      @(negedge clock);
      respReady = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] expData [5];
      logic [3:0]  expTag  [5];
      int          got;
      bit          extra;
      expData[0] = floatToInt(32'h40000000); expTag[0] = 4'd15;
      for (int i = 0; i < 4; i++) begin
         expData[i+1] = intToFloat(32'(i + 1));
         expTag[i+1]  = 4'(i);
      end
      // A held response keeps the FSM busy so four pushes fill the FIFO.
      reqValid = 1'b1; reqCommand = COMMAND_OP_FLOAT_INT;
      reqOperand1 = 32'h40000000; reqOperand2 = '0; reqTag = 4'd15;
      @(posedge clock);
      @(negedge clock); reqValid = 1'b0;
      repeat (3) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         reqValid = 1'b1; reqCommand = COMMAND_OP_INT_FLOAT;
         reqOperand1 = 32'(i + 1); reqTag = 4'(i);
         checks++;
         if (reqReady !== 1'b1) begin
            failures++; $display("FAIL fill_ready_%0d got %b want 1", i, reqReady);
         end
         @(posedge clock);
         @(negedge clock);
      end
      reqValid = 1'b0;
      checks++;
      if (reqReady !== 1'b0) begin
         failures++; $display("FAIL fill_full got ready=%b want 0", reqReady);
      end
      // Offer one more request while full; it must be refused.
      reqValid = 1'b1; reqTag = 4'd7; reqOperand1 = 32'd77;
      @(posedge clock);
      @(negedge clock);
      reqValid = 1'b0;
      respReady = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (respValid) begin
            checks++;
            if ({respData, respTag, respError} !== {expData[got], expTag[got], 1'b0}) begin
               failures++;
               $display("FAIL drain_%0d got d=%h t=%0d e=%b want %h/%0d/0", got,
                        respData, respTag, respError, expData[got], expTag[got]);
            end
            got++;
         end
         @(negedge clock);
      end
      checks++;
      if (got != 5) begin
         failures++; $display("FAIL drain_count got %0d want 5", got);
      end
      extra = 1'b0;
      repeat (10) begin
         if (respValid) extra = 1'b1;
         @(negedge clock);
      end
      respReady = 1'b0;
      checks++;
      if ({extra, idle} !== 2'b01) begin
         failures++; $display("FAIL drain_no_extra got extra=%b idle=%b want 0/1", extra, idle);
      end
   endtask

   task automatic test_reset_mid_issue();
      bit saw;
      reqValid = 1'b1; reqCommand = COMMAND_OP_FLOAT_INT;
      reqOperand1 = 32'h41200000; reqTag = 4'd6;
      @(posedge clock);
      @(negedge clock); reqValid = 1'b0;
      @(negedge clock);          // in ISSUE
      reset_n = 1'b0;
      #1;
      checks++;
      if ({respValid, idle, reqReady} !== 3'b011) begin
         failures++;
         $display("FAIL rst_issue got valid=%b idle=%b ready=%b want 0/1/1",
                  respValid, idle, reqReady);
      end
      @(negedge clock);
      reset_n = 1'b1;
      respReady = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clock);
         if (respValid) saw = 1'b1;
      end
      respReady = 1'b0;
      checks++;
      if ({saw, idle, coreCommand} !== {1'b0, 1'b1, COMMAND_NOP}) begin
         failures++;
         $display("FAIL rst_no_resp got saw=%b idle=%b cmd=%0d want 0/1/0", saw, idle,
                  coreCommand);
      end
   endtask

   task automatic test_random();
      bit      pushFire;
      bit      popFire;
      Expected e;
      Expected f;
      for (int cyc = 0; cyc < 800; cyc++) begin
         reqValid    = ($urandom_range(0, 2) != 0);
         reqCommand  = Commands'(3'($urandom_range(0, 4)));
         reqOperand1 = $urandom();
         reqOperand2 = $urandom();
         reqTag      = 4'($urandom_range(0, 15));
         respReady   = ($urandom_range(0, 3) != 0);
         pushFire = reqValid && reqReady;
         popFire  = respValid && respReady;
         if (popFire) begin
            checks++;
            if (expectQ.size() == 0) begin
               failures++; $display("FAIL rand_unexpected got tag=%0d want none", respTag);
            end else begin
               f = expectQ.pop_front();
               if ({respData, respTag, respError} !== {f.data, f.tag, f.error}) begin
                  failures++;
                  $display("FAIL rand_resp got d=%h t=%0d e=%b want %h/%0d/%b",
                           respData, respTag, respError, f.data, f.tag, f.error);
               end
            end
         end
         if (pushFire) begin
            e.tag = reqTag;
            if (reqCommand == COMMAND_OP_FLOAT_INT || reqCommand == COMMAND_OP_INT_FLOAT) begin
               e.data  = coreFunc(reqCommand, reqOperand1, reqOperand2);
               e.error = 1'b0;
            end else begin
               e.data  = 32'h0;
               e.error = 1'b1;
            end
            expectQ.push_back(e);
         end
         @(posedge clock);
         @(negedge clock);
      end
      reqValid  = 1'b0;
      respReady = 1'b1;
      for (int c = 0; c < 200 && expectQ.size() > 0; c++) begin
         if (respValid) begin
            f = expectQ.pop_front();
            checks++;
            if ({respData, respTag, respError} !== {f.data, f.tag, f.error}) begin
               failures++;
               $display("FAIL rand_drain got d=%h t=%0d e=%b want %h/%0d/%b",
                        respData, respTag, respError, f.data, f.tag, f.error);
            end
         end
         @(negedge clock);
      end
      respReady = 1'b0;
      checks++;
      if (expectQ.size() != 0 || idle !== 1'b1) begin
         failures++;
         $display("FAIL rand_end got pending=%0d idle=%b want 0/1", expectQ.size(), idle);
      end
   endtask

`ifdef FP_DISPATCH_PERF_EN
   task automatic test_perf_wrap();
      int pushes;
      int responses;
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (opCount !== 16'd0) begin
         failures++; $display("FAIL perf_reset got %0d want 0", opCount);
      end
      pushes = 0; responses = 0;
      reqCommand = COMMAND_OP_ADD; reqTag = 4'd1;
      respReady = 1'b1;
      for (int c = 0; c < 300000 && responses < 65537; c++) begin
         reqValid = (pushes < 65537);
         if (reqValid && reqReady) pushes++;
         if (respValid && respReady) responses++;
         @(posedge clock);
         @(negedge clock);
      end
      reqValid = 1'b0;
      respReady = 1'b0;
      checks++;
      if (responses != 65537 || opCount !== 16'd1) begin
         failures++;
         $display("FAIL perf_wrap got responses=%0d count=%0d want 65537/1", responses, opCount);
      end
   endtask
`endif

   initial begin
      @(negedge clock);
      test_reset();
      test_float_int();
      test_int_float();
      test_unsupported();
      test_back_to_back();
      test_reset_mid_issue();
      test_random();
`ifdef FP_DISPATCH_PERF_EN
      test_perf_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_dispatch.md
FP_DISPATCH -- requirements
Module: fp_dispatch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the request FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the core cycles from operand issue to result capture (1..7).
REQ-003 Port aClock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port aReset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port aReqValid, input, 1: a request is presented.
REQ-006 Port aReqReady, output, 1: the request FIFO can accept.
REQ-007 Port aReqCommand, input, Commands: the requested operation.
REQ-008 Port aReqOperand1, input, 32: first operand.
REQ-009 Port aReqOperand2, input, 32: second operand.
REQ-010 Port aReqTag, input, 4: requester tag, returned unchanged.
REQ-011 Port aCoreCommand, output, Commands: registered command to the FP core.
REQ-012 Port aCoreInput1, output, 32: registered first operand to the FP core.
REQ-013 Port aCoreInput2, output, 32: registered second operand to the FP core.
REQ-014 Port aCoreOutput, input, 32: FP core result.
REQ-015 Port aRespValid, output, 1: a response is held.
REQ-016 Port aRespReady, input, 1: the consumer accepts the response.
REQ-017 Port aRespData, output, 32: result data.
REQ-018 Port aRespTag, output, 4: tag of the response.
REQ-019 Port aRespError, output, 1: the command was unsupported.
REQ-020 Port anIdle, output, 1: FIFO empty and FSM in IDLE.

Function
REQ-021 A request SHALL be pushed on each rising edge with aReqValid=1 and aReqReady=1; aReqReady SHALL equal "FIFO not full", with no same-cycle pass-through when full.
REQ-022 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-023 IDLE: when the FIFO is non-empty, the FSM SHALL load the head's command and operands into the aCore* registers and go to ISSUE.
REQ-024 ISSUE SHALL last exactly LATENCY cycles; on its final edge the FSM SHALL capture aCoreOutput into aRespData, set aRespTag to the head tag, pop the FIFO and go to RESP.
REQ-025 A command other than COMMAND_OP_FLOAT_INT or COMMAND_OP_INT_FLOAT SHALL skip ISSUE and go straight from IDLE to RESP with aRespData=0, aRespError=1 and the entry popped.
REQ-026 RESP SHALL hold aRespValid=1 and all aResp* values stable until an edge with aRespReady=1, then go to IDLE.
REQ-027 With LATENCY=1, for a request pushed at edge E0 into an empty FIFO in IDLE, aRespValid SHALL rise after edge E0+2 (in general E0+1+LATENCY).
REQ-028 aCore* registers SHALL hold their last values outside ISSUE.
REQ-029 The FIFO SHALL preserve order; a push and a pop on the same edge SHALL both take effect and leave the count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 While aReset_n=0: FSM in IDLE, FIFO empty, aReqReady=1, aRespValid=0, aRespError=0, aRespData=0, aRespTag=0, aCore* all 0, anIdle=1.
REQ-032 Reset asserted mid-ISSUE or mid-RESP SHALL drop all pending work without emitting a response.

Configuration
REQ-033 With FP_DISPATCH_PERF_EN defined, the block SHALL add output anOpCount, 16 bits, reset 0, incremented on each response handshake and wrapping 0xFFFF->0x0000.
REQ-034 Without FP_DISPATCH_PERF_EN, the anOpCount port and counter SHALL be absent.

Structure
REQ-035 The FSM state typedef and the tag-width constant SHALL live in the shared types header next to Commands.
REQ-036 The FIFO SHALL be a sub-module named fp_dispatch_fifo, parameterised by DEPTH and entry width.

Verification
REQ-037 The bench SHALL cover: FLOAT_INT, op1=0x3F800000, tag 3, core model returns 1 -> aRespData=0x00000001, aRespTag=3, aRespError=0, aRespValid rising 2 edges after the push.
REQ-038 The bench SHALL cover: INT_FLOAT, op1=0x00000005 -> aRespData=0x40A00000 and aCoreCommand=COMMAND_OP_INT_FLOAT during ISSUE.
REQ-039 The bench SHALL cover: 4 pushes with aRespReady=0 -> aReqReady=0 after the 4th; responses drain in tag order 0,1,2,3 once aRespReady=1.
REQ-040 The bench SHALL cover: an unsupported command -> aRespError=1, aRespData=0, and no ISSUE cycle.
REQ-041 The bench SHALL cover: aReset_n pulsed low during ISSUE -> aRespValid=0, anIdle=1, and no response after release.
REQ-042 The bench SHALL cover, with FP_DISPATCH_PERF_EN defined: 65537 responses -> anOpCount=1.
